// File: rtl/calc_log_if.sv
// Capture/drain bundle between the calculator, the result logger and its consumer.
// Carries drop_cnt only when CALC_LOG_DROP_CNT_EN is defined.
interface calc_log_if #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned ADDR_W = 3
);
    logic              clr;
    logic              cap_en;
    logic [DATA_W-1:0] in_result;
    logic [CNT_W-1:0]  in_count;
    logic              log_valid;
    logic              log_ready;
    logic [DATA_W-1:0] log_result;
    logic [CNT_W-1:0]  log_count;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overflow;
`ifdef CALC_LOG_DROP_CNT_EN
    logic [7:0]        drop_cnt;

    modport master (
        output clr, cap_en, in_result, in_count, log_ready,
        input  log_valid, log_result, log_count, level, full, overflow, drop_cnt
    );
    modport slave (
        input  clr, cap_en, in_result, in_count, log_ready,
        output log_valid, log_result, log_count, level, full, overflow, drop_cnt
    );
`else
    modport master (
        output clr, cap_en, in_result, in_count, log_ready,
        input  log_valid, log_result, log_count, level, full, overflow
    );
    modport slave (
        input  clr, cap_en, in_result, in_count, log_ready,
        output log_valid, log_result, log_count, level, full, overflow
    );
`endif
endinterface

// File: rtl/calc_result_logger.sv
// First-word fall-through FIFO capturing {counter, result} pairs from the calculator.
// Optional saturating drop counter when CALC_LOG_DROP_CNT_EN is defined.
module calc_result_logger #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input logic      clk,
    input logic      rst,
    calc_log_if.slave bus
);
    localparam int unsigned LVL_W = ADDR_W + 1;

    typedef struct packed {
        logic [CNT_W-1:0]  count;
        logic [DATA_W-1:0] result;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q;

    logic   empty_c;
    logic   full_c;
    logic   push_c;
    logic   pop_c;
    logic   drop_c;
    entry_t head_c;

    // Handshake decode; clr suppresses push, pop and drop in its cycle
    always_comb begin
        empty_c = (level_q == '0);
        full_c  = (level_q == LVL_W'(DEPTH));
        pop_c   = !empty_c && bus.log_ready && !bus.clr;
        push_c  = bus.cap_en && (!full_c || pop_c) && !bus.clr;
        drop_c  = bus.cap_en && full_c && !pop_c && !bus.clr;
        head_c  = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (drop_c) overflow_q <= 1'b1;
        end
    end

    // Storage has no reset; validity is tracked by level_q alone
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= '{count: bus.in_count, result: bus.in_result};
    end

`ifdef CALC_LOG_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             drop_cnt_q <= '0;
        else if (bus.clr)                     drop_cnt_q <= '0;
        else if (drop_c && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + 8'(1);
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.log_valid  = !empty_c;
    assign bus.log_result = empty_c ? '0 : head_c.result;
    assign bus.log_count  = empty_c ? '0 : head_c.count;
    assign bus.level      = level_q;
    assign bus.full       = full_c;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_calc_result_logger.sv
// Randomized and directed bench for calc_result_logger against a queue-based reference model.
module tb_calc_result_logger;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef struct {
        logic [DATA_W-1:0] res;
        logic [CNT_W-1:0]  cnt;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ent_t model_q[$];
    bit   model_ovf;
    int   model_drops;

    calc_log_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

    calc_result_logger #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf   = 1'b0;
        model_drops = 0;
    endtask

    task automatic compare_all();
        ent_t h;
        h.res = '0;
        h.cnt = '0;
        if (model_q.size() != 0) h = model_q[0];
        check("log_valid", 32'(bus.log_valid), 32'(model_q.size() != 0));
        check("log_result", 32'(bus.log_result), 32'(h.res));
        check("log_count", 32'(bus.log_count), 32'(h.cnt));
        check("level", 32'(bus.level), 32'(model_q.size()));
        check("full", 32'(bus.full), 32'(model_q.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(model_ovf));
`ifdef CALC_LOG_DROP_CNT_EN
        check("drop_cnt", 32'(bus.drop_cnt), 32'(model_drops));
`endif
    endtask

    // Drive one cycle from the falling edge, apply the rules at the rising edge, check after it
    task automatic step(input logic cap, input logic [DATA_W-1:0] res, input logic [CNT_W-1:0] cnt,
                        input logic rdy, input logic cl);
        bit   did_pop;
        ent_t e;
        bus.cap_en    = cap;
        bus.in_result = res;
        bus.in_count  = cnt;
        bus.log_ready = rdy;
        bus.clr       = cl;
        @(posedge clk);
        if (cl) begin
            model_reset();
        end else begin
            did_pop = rdy && (model_q.size() > 0);
            if (did_pop) void'(model_q.pop_front());
            if (cap && (model_q.size() < DEPTH)) begin
                e.res = res;
                e.cnt = cnt;
                model_q.push_back(e);
            end else if (cap) begin
                model_ovf = 1'b1;
                if (model_drops < 255) model_drops++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();

        // Reset held with capture requested: nothing may enter
        rst           = 1'b0;
        bus.clr       = 1'b0;
        bus.cap_en    = 1'b1;
        bus.in_result = 9'd5;
        bus.in_count  = 9'd3;
        bus.log_ready = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        check("rst_valid", 32'(bus.log_valid), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        rst = 1'b1;

        // Single pass
        step(1'b1, 9'd25, 9'd7, 1'b0, 1'b0);
        check("single_result", 32'(bus.log_result), 32'd25);
        check("single_count", 32'(bus.log_count), 32'd7);
        check("single_level", 32'(bus.level), 32'd1);
        step(1'b0, 9'd0, 9'd0, 1'b1, 1'b0);
        check("single_empty", 32'(bus.log_valid), 32'd0);

        // Fill past capacity
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, DATA_W'(i), CNT_W'(i + 100), 1'b0, 1'b0);
            if (i == 8) check("fill_full", 32'(bus.full), 32'd1);
            if (i == 8) check("fill_no_ovf", 32'(bus.overflow), 32'd0);
            if (i == 9) check("fill_ovf", 32'(bus.overflow), 32'd1);
        end
`ifdef CALC_LOG_DROP_CNT_EN
        check("fill_drops", 32'(bus.drop_cnt), 32'd2);
`endif
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", 32'(bus.log_result), 32'(i));
            step(1'b0, 9'd0, 9'd0, 1'b1, 1'b0);
        end

        // Full with simultaneous capture and pop
        for (int i = 11; i <= 18; i++) step(1'b1, DATA_W'(i), CNT_W'(i), 1'b0, 1'b0);
        step(1'b1, 9'd99, 9'd42, 1'b1, 1'b0);
        check("simul_level", 32'(bus.level), 32'd8);
        check("simul_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("simul_last", 32'(bus.log_result), 32'd99);
            step(1'b0, 9'd0, 9'd0, 1'b1, 1'b0);
        end

        // Continuous push/pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DATA_W'(200 + i), CNT_W'(i), 1'b1, 1'b0);
            check("wrap_level", 32'(bus.level), 32'd1);
            check("wrap_data", 32'(bus.log_result), 32'(200 + i));
        end
        step(1'b0, 9'd0, 9'd0, 1'b1, 1'b0);

        // Clear beats a same-cycle capture
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(50 + i), CNT_W'(i), 1'b0, 1'b0);
        step(1'b1, 9'd77, 9'd77, 1'b0, 1'b1);
        check("clr_level", 32'(bus.level), 32'd0);
        check("clr_valid", 32'(bus.log_valid), 32'd0);
        check("clr_ovf", 32'(bus.overflow), 32'd0);

        // Random traffic with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge clk);
                rst = 1'b1;
            end
            step(1'($urandom_range(0, 99) < 60), DATA_W'($urandom), CNT_W'($urandom),
                 1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
